// File: rtl/hazard_scheduler_pkg.sv
// Shared constants and shadow-record types for the ID-side hazard scheduler.
// Opcode/funct values are the MIPS encodings used by the source-usage decoder.
package hazard_scheduler_pkg;

    localparam int OP_W  = 6;
    localparam int FN_W  = 6;
    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'd9;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd10;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd12;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd13;
    localparam logic [OP_W-1:0] OP_LW    = 6'd35;
    localparam logic [OP_W-1:0] OP_SW    = 6'd43;

    localparam logic [FN_W-1:0] F_SLL     = 6'd0;
    localparam logic [FN_W-1:0] F_SRL     = 6'd2;
    localparam logic [FN_W-1:0] F_SRA     = 6'd3;
    localparam logic [FN_W-1:0] F_JR      = 6'd8;
    localparam logic [FN_W-1:0] F_SYSCALL = 6'd12;
    localparam logic [FN_W-1:0] F_ADD     = 6'd32;
    localparam logic [FN_W-1:0] F_ADDU    = 6'd33;
    localparam logic [FN_W-1:0] F_SUB     = 6'd34;
    localparam logic [FN_W-1:0] F_AND     = 6'd36;
    localparam logic [FN_W-1:0] F_OR      = 6'd37;
    localparam logic [FN_W-1:0] F_NOR     = 6'd39;
    localparam logic [FN_W-1:0] F_SLT     = 6'd42;
    localparam logic [FN_W-1:0] F_SLTU    = 6'd43;

    // MEM/WB only ever need the destination part of a record.
    typedef struct packed {
        logic             valid;
        logic             wr;
        logic [REG_W-1:0] dst;
    } dst_rec_t;

    typedef struct packed {
        dst_rec_t         d;
        logic             load;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             r1u;
        logic             r2u;
    } shadow_rec_t;

    function automatic logic rec_match(dst_rec_t s, logic [REG_W-1:0] r);
        return s.valid & s.wr & (s.dst != '0) & (s.dst == r);
    endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// ID-stage request / pipeline-control response bundle between the datapath and the scheduler.
interface hazard_scheduler_if
    import hazard_scheduler_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             en;
    logic [OP_W-1:0]  id_op;
    logic [FN_W-1:0]  id_func;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_dst;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             ex_branch;
    logic             stall;
    logic             bubble_ex;
    logic             flush_id;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output en, id_op, id_func, id_rs, id_rt, id_dst, id_reg_write, id_mem_read, ex_branch,
        input  stall, bubble_ex, flush_id, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  en, id_op, id_func, id_rs, id_rt, id_dst, id_reg_write, id_mem_read, ex_branch,
        output stall, bubble_ex, flush_id, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_scheduler_src_usage_decode.sv
// Decodes which register sources (rs -> r1u, rt -> r2u) an ID instruction actually reads.
module hazard_scheduler_src_usage_decode
    import hazard_scheduler_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [FN_W-1:0] func_i,
    output logic            r1u_o,
    output logic            r2u_o
);

    always_comb begin
        r1u_o = 1'b0;
        r2u_o = 1'b0;
        if (op_i == OP_RTYPE) begin
            case (func_i)
                F_JR:                 r1u_o = 1'b1;
                F_SLL, F_SRL, F_SRA:  r2u_o = 1'b1;
                F_SYSCALL, F_ADD, F_ADDU, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLTU: begin
                    r1u_o = 1'b1;
                    r2u_o = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (op_i)
                OP_BEQ, OP_BNE, OP_SW: begin
                    r1u_o = 1'b1;
                    r2u_o = 1'b1;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: r1u_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// RAW hazard scheduler beside ID: shadow EX/MEM/WB destination tracking, stall/bubble/flush,
// EX forwarding selects and wrapping stall/flush event counters.
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter bit FORWARDING = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_scheduler_if.slave bus
);

    logic        r1u, r2u;
    shadow_rec_t ex_q, ex_d;
    dst_rec_t    mem_q, wb_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic        ex_hit, mem_hit, stall_raw;
    logic        stall, bubble_ex, flush_id;
    logic [1:0]  fwd_a, fwd_b;

    hazard_scheduler_src_usage_decode u_dec (
        .op_i   (bus.id_op),
        .func_i (bus.id_func),
        .r1u_o  (r1u),
        .r2u_o  (r2u)
    );

    assign ex_hit  = (r1u & rec_match(ex_q.d, bus.id_rs)) | (r2u & rec_match(ex_q.d, bus.id_rt));
    assign mem_hit = (r1u & rec_match(mem_q, bus.id_rs))  | (r2u & rec_match(mem_q, bus.id_rt));
    // WB never hazards: the register file writes in the first half-cycle.
    assign stall_raw = FORWARDING ? (ex_hit & ex_q.load) : (ex_hit | mem_hit);

    always_comb begin
        if (bus.ex_branch) begin
            stall     = 1'b0;
            bubble_ex = 1'b1;
            flush_id  = 1'b1;
        end else begin
            stall     = stall_raw;
            bubble_ex = stall_raw;
            flush_id  = 1'b0;
        end
    end

    always_comb begin
        ex_d = '0;
        if (!bubble_ex) begin
            ex_d.d.valid = 1'b1;
            ex_d.d.wr    = bus.id_reg_write;
            ex_d.d.dst   = bus.id_dst;
            ex_d.load    = bus.id_mem_read;
            ex_d.rs      = bus.id_rs;
            ex_d.rt      = bus.id_rt;
            ex_d.r1u     = r1u;
            ex_d.r2u     = r2u;
        end
    end

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FORWARDING && ex_q.d.valid) begin
            if (ex_q.r1u) begin
                if (rec_match(mem_q, ex_q.rs))     fwd_a = FWD_EXMEM;
                else if (rec_match(wb_q, ex_q.rs)) fwd_a = FWD_MEMWB;
            end
            if (ex_q.r2u) begin
                if (rec_match(mem_q, ex_q.rt))     fwd_b = FWD_EXMEM;
                else if (rec_match(wb_q, ex_q.rt)) fwd_b = FWD_MEMWB;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.en) begin
            wb_q        <= mem_q;
            mem_q       <= ex_q.d;
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
            flush_cnt_q <= flush_cnt_q + CNT_W'(bus.ex_branch);
        end
    end

    assign bus.stall     = stall;
    assign bus.bubble_ex = bubble_ex;
    assign bus.flush_id  = flush_id;
    assign bus.fwd_a     = fwd_a;
    assign bus.fwd_b     = fwd_b;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule
